// File: rtl/adaptive_traffic_controller.sv
// +--------------------------------------------------------------------------+
// | Module      : adaptive_traffic_controller                                |
// | Description : Two-road traffic light FSM with traffic-adaptive green,    |
// |               yellow/all-red clearance and a flashing night mode.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module adaptive_traffic_controller #(
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 60,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ta,
    input  logic             tb,
    input  logic             flash,
    output logic             ra,
    output logic             ya,
    output logic             ga,
    output logic             rb,
    output logic             yb,
    output logic             gb,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] timer
);

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_YEL = 3'd1,
        AR_AB = 3'd2,
        B_GRN = 3'd3,
        B_YEL = 3'd4,
        AR_BA = 3'd5,
        FLASH = 3'd6
    } state_t;

    // Elapsed-count comparisons use one extra bit so e never wraps.
    localparam logic [CNT_W:0]   GMIN_E = (CNT_W+1)'(GREEN_MIN);
    localparam logic [CNT_W:0]   GMAX_E = (CNT_W+1)'(GREEN_MAX);
    localparam logic [CNT_W:0]   YEL_E  = (CNT_W+1)'(YELLOW_T);
    localparam logic [CNT_W:0]   AR_E   = (CNT_W+1)'(ALLRED_T);
    localparam logic [CNT_W-1:0] GMAX_T = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] ONES_T = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             blink_q, blink_d;
    logic [CNT_W:0]   e;
    logic             green;

    assign e     = {1'b0, timer_q} + {{CNT_W{1'b0}}, 1'b1};
    assign green = (state_q == A_GRN) || (state_q == B_GRN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= A_GRN;
            timer_q <= '0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        blink_d = blink_q;
        if (tick) begin
            case (state_q)
                A_GRN: if (flash || (tb && ((e >= GMIN_E && !ta) || e >= GMAX_E)))
                           state_d = A_YEL;
                B_GRN: if (flash || (ta && ((e >= GMIN_E && !tb) || e >= GMAX_E)))
                           state_d = B_YEL;
                A_YEL: if (e == YEL_E) state_d = AR_AB;
                B_YEL: if (e == YEL_E) state_d = AR_BA;
                AR_AB: if (e == AR_E)  state_d = flash ? FLASH : B_GRN;
                AR_BA: if (e == AR_E)  state_d = flash ? FLASH : A_GRN;
                FLASH: if (!flash)     state_d = AR_BA;
                default:               state_d = AR_BA;
            endcase

            if (state_d != state_q)
                timer_d = '0;
            else if (green)
                timer_d = (e >= GMAX_E) ? GMAX_T : e[CNT_W-1:0];
            else if (state_q == FLASH)
                timer_d = e[CNT_W] ? ONES_T : e[CNT_W-1:0];
            else
                timer_d = e[CNT_W-1:0];

            blink_d = (state_q == FLASH) ? ~blink_q : 1'b0;
        end
    end

    always_comb begin
        ra = 1'b0;
        ya = 1'b0;
        ga = 1'b0;
        rb = 1'b0;
        yb = 1'b0;
        gb = 1'b0;
        case (state_q)
            A_GRN: begin ga = 1'b1; rb = 1'b1; end
            A_YEL: begin ya = 1'b1; rb = 1'b1; end
            B_GRN: begin ra = 1'b1; gb = 1'b1; end
            B_YEL: begin ra = 1'b1; yb = 1'b1; end
            AR_AB,
            AR_BA: begin ra = 1'b1; rb = 1'b1; end
            FLASH: begin ya = blink_q; yb = blink_q; end
            default: ;
        endcase
    end

    assign state = state_q;
    assign timer = timer_q;

endmodule

`default_nettype wire

// File: tb/tb_adaptive_traffic_controller.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_adaptive_traffic_controller                             |
// | Description : Directed vector bench for adaptive_traffic_controller.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_adaptive_traffic_controller;

    localparam logic [2:0] AG  = 3'd0, AY = 3'd1, RAB = 3'd2, BG = 3'd3,
                           BY  = 3'd4, RBA = 3'd5, FL = 3'd6;
    // Lamp order {ra, ya, ga, rb, yb, gb}
    localparam logic [5:0] L_AG  = 6'b001100, L_AY  = 6'b010100,
                           L_BG  = 6'b100001, L_BY  = 6'b100010,
                           L_RR  = 6'b100100, L_FL1 = 6'b010010,
                           L_FL0 = 6'b000000;

    typedef struct {
        string      name;
        logic       tk, a, b, fl;
        logic [2:0] st;
        logic [7:0] tm;
        logic [5:0] lp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, tick, ta, tb, flash;
    logic       ra, ya, ga, rb, yb, gb;
    logic [2:0] state;
    logic [7:0] timer;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    adaptive_traffic_controller #(
        .CNT_W(8), .GREEN_MIN(3), .GREEN_MAX(6), .YELLOW_T(2), .ALLRED_T(1)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .ta(ta), .tb(tb), .flash(flash),
        .ra(ra), .ya(ya), .ga(ga), .rb(rb), .yb(yb), .gb(gb),
        .state(state), .timer(timer)
    );

    always #5 clk = ~clk;

    task automatic add(input string n, input logic tk, input logic a, input logic b,
                       input logic fl, input logic [2:0] st, input int tm,
                       input logic [5:0] lp);
        vec_t v;
        v.name = n; v.tk = tk; v.a = a; v.b = b; v.fl = fl;
        v.st = st; v.tm = 8'(tm); v.lp = lp;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [2:0] es, input logic [7:0] et,
                         input logic [5:0] el);
        logic [5:0] al;
        al = {ra, ya, ga, rb, yb, gb};
        n_vec++;
        if (state !== es || timer !== et || al !== el) begin
            n_err++;
            $display("FAIL %s: got state=%0d timer=%0d lamps=%b, expected state=%0d timer=%0d lamps=%b",
                     n, state, timer, al, es, et, el);
        end
    endtask

    initial begin
        // Minimum-green full cycle, with a held non-tick cycle carrying junk inputs
        add("mg_ag1", 1,0,1,0, AG, 1, L_AG);
        add("mg_hold",0,1,0,1, AG, 1, L_AG);
        add("mg_ag2", 1,0,1,0, AG, 2, L_AG);
        add("mg_ay0", 1,0,1,0, AY, 0, L_AY);
        add("mg_ay1", 1,0,1,0, AY, 1, L_AY);
        add("mg_rab", 1,0,1,0, RAB,0, L_RR);
        add("mg_bg0", 1,0,1,0, BG, 0, L_BG);
        add("mg_bg1", 1,1,0,0, BG, 1, L_BG);
        add("mg_bg2", 1,1,0,0, BG, 2, L_BG);
        add("mg_by0", 1,1,0,0, BY, 0, L_BY);
        add("mg_by1", 1,1,0,0, BY, 1, L_BY);
        add("mg_rba", 1,1,0,0, RBA,0, L_RR);
        add("mg_ag0", 1,1,0,0, AG, 0, L_AG);
        for (int k = 1; k <= 5; k++) add("mx_ag", 1,1,1,0, AG, k, L_AG);
        add("mx_ay0", 1,1,1,0, AY, 0, L_AY);
        add("mx_ay1", 1,1,1,0, AY, 1, L_AY);
        add("mx_rab", 1,1,1,0, RAB,0, L_RR);
        add("mx_bg0", 1,1,1,0, BG, 0, L_BG);
        add("fl_by0", 1,1,1,1, BY, 0, L_BY);
        add("fl_by1", 1,1,1,1, BY, 1, L_BY);
        add("fl_rba", 1,1,1,1, RBA,0, L_RR);
        add("fl_fl0", 1,1,1,1, FL, 0, L_FL0);
        add("fl_fl1", 1,1,1,1, FL, 1, L_FL1);
        add("fl_fl2", 1,1,1,1, FL, 2, L_FL0);
        add("fl_hold",0,1,1,0, FL, 2, L_FL0);
        add("fl_fl3", 1,1,1,1, FL, 3, L_FL1);
        add("fl_exit",1,1,1,0, RBA,0, L_RR);
        add("fl_ag0", 1,1,1,0, AG, 0, L_AG);
        for (int k = 1; k <= 20; k++) add("sat_ag", 1,1,0,0, AG, (k < 6) ? k : 6, L_AG);
        add("to_ay0", 1,0,1,0, AY, 0, L_AY);
        add("to_ay1", 1,0,1,0, AY, 1, L_AY);
        add("to_rab", 1,0,1,0, RAB,0, L_RR);
        add("to_bg0", 1,0,1,0, BG, 0, L_BG);
        add("to_bg1", 1,1,0,0, BG, 1, L_BG);
        add("to_bg2", 1,1,0,0, BG, 2, L_BG);
        add("to_by0", 1,1,0,0, BY, 0, L_BY);

        rst = 1'b0; tick = 1'b1; ta = 1'b0; tb = 1'b1; flash = 1'b0;
        #1;
        check("reset_async", AG, 8'd0, L_AG);

        @(negedge clk);
        rst = 1'b1;
        foreach (vecs[i]) begin
            tick = vecs[i].tk; ta = vecs[i].a; tb = vecs[i].b; flash = vecs[i].fl;
            @(posedge clk);
            #1;
            check(vecs[i].name, vecs[i].st, vecs[i].tm, vecs[i].lp);
            @(negedge clk);
        end

        // Reset pulse between edges while in B_YEL
        tick = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_reset", AG, 8'd0, L_AG);

        // Sparse tick: one tick every 4 cycles, junk inputs on the idle cycles
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick = (c % 4 == 3);
            if (tick) begin ta = 1'b0; tb = 1'b1; flash = 1'b0; end
            else      begin ta = 1'b1; tb = 1'b0; flash = 1'b1; end
            @(posedge clk);
            #1;
            if (c == 11) check("sparse_exit", AY, 8'd0, L_AY);
            else         check("sparse_hold", AG, 8'((c + 1) / 4), L_AG);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adaptive_traffic_controller.md
ADAPTIVE_TRAFFIC_CONTROLLER -- requirements
Module: adaptive_traffic_controller

Interface
REQ-001 Parameter CNT_W, default 8: phase timer width in bits.
REQ-002 Parameter GREEN_MIN, default 10: minimum green time, in ticks.
REQ-003 Parameter GREEN_MAX, default 60: maximum green time, in ticks, when the cross road is waiting.
REQ-004 Parameter YELLOW_T, default 4: yellow time, in ticks.
REQ-005 Parameter ALLRED_T, default 2: all-red clearance time, in ticks.
REQ-006 Legal parameter values SHALL be 1 <= GREEN_MIN <= GREEN_MAX < 2^CNT_W, YELLOW_T >= 1, ALLRED_T >= 1, and YELLOW_T and ALLRED_T < 2^CNT_W.
REQ-007 Port clk, input, 1 bit: the only clock; all state SHALL update on its rising edge.
REQ-008 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port tick, input, 1 bit: one-cycle timebase enable.
REQ-010 Port ta, input, 1 bit: traffic present on road A.
REQ-011 Port tb, input, 1 bit: traffic present on road B.
REQ-012 Port flash, input, 1 bit: night-mode request (flashing yellow).
REQ-013 Ports ra, ya, ga, rb, yb, gb, each output, 1 bit: lamp drives for road A and road B.
REQ-014 Port state, output, 3 bits: current FSM state encoding.
REQ-015 Port timer, output, CNT_W bits: ticks elapsed in the current state.

Function
REQ-016 The FSM states SHALL be A_GRN=0, A_YEL=1, AR_AB=2, B_GRN=3, B_YEL=4, AR_BA=5 and FLASH=6; code 7 is illegal and SHALL go to AR_BA on the next tick.
REQ-017 State and timer SHALL change only on cycles with tick=1; with tick=0 every register SHALL hold its value.
REQ-018 On each tick, let e = timer+1; on a state change timer SHALL load 0, otherwise timer SHALL load e saturated at GREEN_MAX in green states and at 2^CNT_W-1 in FLASH.
REQ-019 A_GRN SHALL go to A_YEL when flash=1, or when tb=1 and either (e >= GREEN_MIN and ta=0) or e >= GREEN_MAX.
REQ-020 A_GRN SHALL hold indefinitely while tb=0 and flash=0.
REQ-021 B_GRN SHALL follow the same rules as A_GRN with ta and tb swapped, and SHALL exit to B_YEL.
REQ-022 A_YEL SHALL go to AR_AB when e == YELLOW_T, and B_YEL SHALL go to AR_BA when e == YELLOW_T, regardless of flash.
REQ-023 When e == ALLRED_T, AR_AB SHALL go to FLASH if flash=1 and to B_GRN otherwise.
REQ-024 When e == ALLRED_T, AR_BA SHALL go to FLASH if flash=1 and to A_GRN otherwise.
REQ-025 FLASH SHALL go to AR_BA on the first tick with flash=0.
REQ-026 A blink register SHALL toggle on every tick while in FLASH and SHALL clear to 0 on every tick outside FLASH.
REQ-027 Lamp outputs SHALL be a Moore decode of state and blink:
- A_GRN: ga=1, rb=1.
- A_YEL: ya=1, rb=1.
- B_GRN: ra=1, gb=1.
- B_YEL: ra=1, yb=1.
- AR_AB and AR_BA: ra=1, rb=1.
- FLASH: ya=blink, yb=blink.
- All other lamps 0.
REQ-028 In every state, at most one lamp per road SHALL be on, and ga and gb SHALL never both be 1.
REQ-029 Input changes on cycles with tick=0 SHALL have no effect until the next tick.

Reset
REQ-030 When rst=0, state SHALL go immediately (asynchronously) to A_GRN, with timer=0 and blink=0; the outputs SHALL then be ga=1, rb=1, all other lamps 0.
REQ-031 Reset asserted mid-phase SHALL abandon that phase with no yellow or all-red sequencing.
REQ-032 After rst deasserts, the first state update SHALL occur on the first tick.

Verification (GREEN_MIN=3, GREEN_MAX=6, YELLOW_T=2, ALLRED_T=1, tick=1 every cycle)
REQ-033 Reset check: drive rst=0 -> state=0, timer=0, ga=1, rb=1, other lamps 0, before any clock edge.
REQ-034 Minimum-green cycle: drive ta=0, tb=1, then ta=1, tb=0 once in B_GRN -> dwell times A_GRN 3, A_YEL 2, AR_AB 1, B_GRN 3, B_YEL 2, AR_BA 1 ticks.
REQ-035 Maximum green and saturation:
- ta=1, tb=1 -> A_GRN lasts 6 ticks, then A_YEL.
- tb=0 -> A_GRN holds for 20 ticks, with timer saturated at 6.
REQ-036 Flash entry and exit: assert flash in B_GRN at timer=0 -> B_YEL 2 ticks, AR_BA 1 tick, then FLASH with ya=yb toggling every tick; deassert flash -> AR_BA 1 tick -> A_GRN.
REQ-037 Sparse tick: tick every 4th cycle with ta=0, tb=1 -> A_GRN lasts 12 cycles, and ta/tb pulses between ticks are ignored.
REQ-038 Mid-phase reset: pulse rst=0 during B_YEL between clock edges -> state=0 and ga=1 immediately, with no yellow or all-red.
